// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier.
// The state encoding and opcode values are used by both the RTL and the bench.
package mult_pkg;

    localparam int   DEFAULT_WIDTH = 32;
    localparam logic OP_MULT       = 1'b0;
    localparam logic OP_MULTU      = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/mult_seq_if.sv
// Request/result bundle between the core (master) and the multiplier (slave).
// Vectors are big-endian: bit 0 is the MSB.
interface mult_seq_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic               start;
    logic               op;
    logic [0:WIDTH-1]   a;
    logic [0:WIDTH-1]   b;
    logic               flush;
    logic               busy;
    logic               done;
    logic [0:WIDTH-1]   result_lo;
    logic [0:WIDTH-1]   result_hi;
    logic               ovf;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result_lo, result_hi, ovf
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result_lo, result_hi, ovf
    );

endinterface

// File: rtl/mult_step.sv
// One radix-2 shift-add iteration: conditional add into the upper half, then shift right.
// Purely combinational; no handshake.
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic               lsb_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] wide;

    always_comb begin
        // Carry out of the add lands in bit 2*WIDTH and shifts back into range.
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + ({1'b0, mcand_i} & {(WIDTH+1){lsb_i}});
        wide  = {sum, acc_i[WIDTH-1:0]};
        acc_o = (2*WIDTH)'(wide >> 1);
    end

endmodule

// File: rtl/mult_seq.sv
// Sequential signed/unsigned multiplier: latency WIDTH+2 cycles from start edge to done.
// busy stalls the core; start while busy is dropped, flush aborts without touching results.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    mult_seq_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q;
    logic               op_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   a_w;
    logic [WIDTH-1:0]   b_w;
    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic               neg_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   hi_d;
    logic               ovf_d;

    always_comb begin
        a_w     = bus.a;
        b_w     = bus.b;
        // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
        a_mag_d = (bus.op == OP_MULT && a_w[WIDTH-1]) ? -a_w : a_w;
        b_mag_d = (bus.op == OP_MULT && b_w[WIDTH-1]) ? -b_w : b_w;
        neg_d   = (bus.op == OP_MULT) && (a_w[WIDTH-1] ^ b_w[WIDTH-1]);
        prod_d  = neg_q ? -acc_q : acc_q;
        lo_d    = prod_d[WIDTH-1:0];
        hi_d    = prod_d[2*WIDTH-1:WIDTH];
        ovf_d   = (op_q == OP_MULTU) ? (hi_d != '0)
                                     : (hi_d != {WIDTH{lo_d[WIDTH-1]}});
    end

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .lsb_i   (mplier_q[0]),
        .acc_o   (acc_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            op_q     <= OP_MULT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            ovf_q    <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand_q  <= a_mag_d;
                        mplier_q <= b_mag_d;
                        neg_q    <= neg_d;
                        op_q     <= bus.op;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    lo_q    <= lo_d;
                    hi_q    <= hi_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_lo = lo_q;
    assign bus.result_hi = hi_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed-vector bench for mult_seq with a queue-based scoreboard checked on every done pulse.
module tb_mult_seq;
    import mult_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;
    int   pushed    = 0;
    exp_t sb[$];

    mult_seq_if #(.WIDTH(W)) bus ();

    mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("result_lo", bus.result_lo, e.lo);
                chk("result_hi", bus.result_hi, e.hi);
                chk("ovf", bus.ovf, e.ovf);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, bus.busy, 1'b0);
    endtask

    task automatic do_op(input string name, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] lo,
                         input logic [W-1:0] hi, input logic ovf);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        sb.push_back('{lo, hi, ovf, cyc + 34});
        pushed++;
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, "_busy_rise"}, bus.busy, 1'b1);
        wait_idle(name);
    endtask

    task automatic start_untracked(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_lo", bus.result_lo, 32'h0);
        chk("rst_hi", bus.result_hi, 32'h0);
        chk("rst_ovf", bus.ovf, 1'b0);
        reset = 1'b0;

        do_op("u_ffxff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        do_op("s_m3x7",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
        do_op("u_m3x7",  OP_MULTU, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'h0000_0006, 1'b1);
        do_op("s_minsq", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1);
        do_op("s_minx1", OP_MULT,  32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("s_m1xm1", OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
        do_op("s_2p32",  OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b1);

        // start held high every cycle during an op: only the first is accepted.
        snap = done_seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd5;
        bus.b     = 32'd9;
        sb.push_back('{32'h0000_002D, 32'h0, 1'b0, cyc + 34});
        pushed++;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                bus.start = 1'b0;
                break;
            end
            bus.start = 1'b1;
            bus.a     = 32'(i + 100);
            bus.b     = 32'(i + 3);
        end
        bus.start = 1'b0;
        chk("burst_idle", bus.busy, 1'b0);
        chk("burst_one_done", done_seen, snap + 1);

        do_op("u_6x7", OP_MULTU, 32'd6, 32'd7, 32'h0000_002A, 32'h0, 1'b0);

        // flush mid-RUN: no done, results from 6x7 retained.
        snap = done_seen;
        start_untracked(OP_MULTU, 32'd100, 32'd100);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 1'b0);
        repeat (40) @(negedge clk);
        chk("flush_no_done", done_seen, snap);
        chk("flush_lo", bus.result_lo, 32'h0000_002A);
        chk("flush_hi", bus.result_hi, 32'h0);
        chk("flush_ovf", bus.ovf, 1'b0);

        // async reset between edges mid-RUN after an overflowing result.
        do_op("u_ovf_pre", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        start_untracked(OP_MULT, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_lo", bus.result_lo, 32'h0);
        chk("arst_hi", bus.result_hi, 32'h0);
        chk("arst_ovf", bus.ovf, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        do_op("u_post_rst", OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 1'b1);

        repeat (5) @(negedge clk);
        chk("done_total", done_seen, pushed);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
